// File: rtl/mel_feat_buf_if.sv
// Stream bundle between the mel producer, mel_feat_buf and the downstream classifier.
// Handshake: a window word moves on every rising edge where feat_vld && feat_rdy are both
// high; once feat_vld rises, feat_data/feat_last hold until that transfer happens.
// mel_avail is a one-cycle strobe with no back-pressure.
interface mel_feat_buf_if #(
    parameter int WIDTH = 16
);
    logic             mel_avail;
    logic [WIDTH-1:0] mel_data;
    logic             win_rdy;
    logic             rd_start;
    logic             rd_busy;
    logic             feat_vld;
    logic             feat_rdy;
    logic [WIDTH-1:0] feat_data;
    logic             feat_last;
    logic             rd_done;
    logic [7:0]       drop_cnt;

    modport master (
        output mel_avail, mel_data, rd_start, feat_rdy,
        input  win_rdy, rd_busy, feat_vld, feat_data, feat_last, rd_done, drop_cnt
    );

    modport slave (
        input  mel_avail, mel_data, rd_start, feat_rdy,
        output win_rdy, rd_busy, feat_vld, feat_data, feat_last, rd_done, drop_cnt
    );
endinterface

// File: rtl/mel_feat_buf.sv
// mel_feat_buf: circular frame store for mel words that serves the newest N_FRAMES complete
// frames, oldest first, to a downstream consumer. A spare slot lets one frame be written
// while a window is read. Define MEL_FEAT_LOG_EN to store a fixed-point log2 of each word
// (adds one write-path register stage).
module mel_feat_buf #(
    parameter int WIDTH     = 16,
    parameter int MEL_BANDS = 40,
    parameter int N_FRAMES  = 101
) (
    input  logic         clk,
    input  logic         rst_n,
    mel_feat_buf_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int NS     = N_FRAMES + 1;
    localparam int TOTAL  = N_FRAMES * MEL_BANDS;
    localparam int SLOT_W = $clog2(NS);
    localparam int BAND_W = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;
    localparam int ADDR_W = $clog2(NS * MEL_BANDS);
    localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CNT_W  = $clog2(N_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NS - 1);
    localparam logic [SLOT_W-1:0] SLOT_NF   = SLOT_W'(N_FRAMES);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(MEL_BANDS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_FRAMES);
    localparam logic [ADDR_W-1:0] BANDS_A   = ADDR_W'(MEL_BANDS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == SLOT_LAST) ? '0 : s + SLOT_W'(1);
    endfunction

    // ---------------- write-path input (optionally log-converted) ----------------
    logic             w_avail;
    logic [WIDTH-1:0] w_data;

`ifdef MEL_FEAT_LOG_EN
    localparam int L = $clog2(WIDTH);

    // Leading-one position in the top L bits, the bits below it MSB-aligned underneath.
    function automatic logic [WIDTH-1:0] log2_fix(input logic [WIDTH-1:0] x);
        int               pos;
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] r;
        pos = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i]) pos = i;
        sh = x << (WIDTH - pos);
        r  = '0;
        if (x != '0) begin
            r[WIDTH-1:WIDTH-L] = pos[L-1:0];
            r[WIDTH-L-1:0]     = sh[WIDTH-1:L];
        end
        return r;
    endfunction

    logic             l_avail;
    logic [WIDTH-1:0] l_data;

    // Extra register stage holding the converted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_avail <= 1'b0;
            l_data  <= '0;
        end else begin
            l_avail <= bus.mel_avail;
            l_data  <= log2_fix(bus.mel_data);
        end
    end

    assign w_avail = l_avail;
    assign w_data  = l_data;
`else
    assign w_avail = bus.mel_avail;
    assign w_data  = bus.mel_data;
`endif

    // ---------------- write side ----------------
    logic [SLOT_W-1:0] wr_slot, newest, base, off, rd_frm, iss_slot;
    logic [BAND_W-1:0] band, iss_band, rd_band;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [7:0]        drop_cnt;
    logic              frm_drop, blocked, first_band, last_band, wr_en, commit;
    logic              rd_busy, rd_done, win_rdy;
    state_t            state, state_nxt;

    // Distance of the write slot from the window base, modulo the slot count.
    assign off        = (wr_slot >= base) ? wr_slot - base : wr_slot + SLOT_W'(NS) - base;
    assign blocked    = rd_busy && (off >= rd_frm) && (off < SLOT_NF);
    assign first_band = (band == '0);
    assign last_band  = (band == BAND_LAST);
    // The accept/discard decision is made at band 0 and held for the whole frame.
    assign wr_en      = w_avail && !(first_band ? blocked : frm_drop);
    assign commit     = wr_en && last_band;
    assign count_nxt  = (commit && count != CNT_FULL) ? count + CNT_W'(1) : count;

    // Band/slot pointers, frame commit and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band     <= '0;
            wr_slot  <= '0;
            newest   <= '0;
            count    <= '0;
            frm_drop <= 1'b0;
            drop_cnt <= '0;
        end else begin
            count <= count_nxt;
            if (w_avail) begin
                band <= last_band ? '0 : band + BAND_W'(1);
                if (first_band) frm_drop <= blocked;
                if (first_band && blocked && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (commit) begin
                newest  <= wr_slot;
                wr_slot <= slot_inc(wr_slot);
            end
        end
    end

    // ---------------- read FSM ----------------
    logic start_ok, pop, issue, room, iss_all, pend, pend_last;
    logic out_vld, out_last, skid_vld, skid_last;
    logic [WIDTH-1:0] ram_q, out_data, skid_data;
    logic [IDX_W-1:0] iss_idx;
    logic [1:0]       occ;

    assign start_ok = bus.rd_start && win_rdy && (state == S_IDLE);
    assign pop      = out_vld && bus.feat_rdy;
    assign occ      = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, pend};
    // Output + skid register hold two words; only issue a read if it will have a home.
    assign room     = (occ == 2'd0) || (occ == 2'd1) || (occ == 2'd2 && pop);
    assign issue    = rd_busy && !iss_all && room;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        rd_busy   = 1'b0;
        rd_done   = 1'b0;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_LOAD;
            S_LOAD: begin
                rd_busy   = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                rd_busy = 1'b1;
                if (pop && out_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                rd_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Window-ready flag: a full store and no read in progress or starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_rdy <= 1'b0;
        else        win_rdy <= (count_nxt == CNT_FULL) && (state_nxt == S_IDLE);
    end

    // Read pointers; base is latched from the pre-commit newest slot as LOAD is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            iss_slot  <= '0;
            iss_band  <= '0;
            iss_idx   <= '0;
            iss_all   <= 1'b0;
            rd_frm    <= '0;
            rd_band   <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= issue;
            pend_last <= issue && (iss_idx == IDX_LAST);
            if (start_ok) begin
                base     <= slot_inc(slot_inc(newest));
                iss_slot <= slot_inc(slot_inc(newest));
                iss_band <= '0;
                iss_idx  <= '0;
                iss_all  <= 1'b0;
                rd_frm   <= '0;
                rd_band  <= '0;
            end else begin
                if (issue) begin
                    if (iss_band == BAND_LAST) begin
                        iss_band <= '0;
                        iss_slot <= slot_inc(iss_slot);
                    end else begin
                        iss_band <= iss_band + BAND_W'(1);
                    end
                    if (iss_idx == IDX_LAST) iss_all <= 1'b1;
                    else                     iss_idx <= iss_idx + IDX_W'(1);
                end
                if (pop) begin
                    if (rd_band == BAND_LAST) begin
                        rd_band <= '0;
                        rd_frm  <= rd_frm + SLOT_W'(1);
                    end else begin
                        rd_band <= rd_band + BAND_W'(1);
                    end
                end
            end
        end
    end

    // Frame store: one write port, one synchronous read port.
    logic [WIDTH-1:0] mem [0:NS*MEL_BANDS-1];
    always_ff @(posedge clk) begin
        if (wr_en) mem[ADDR_W'(wr_slot) * BANDS_A + ADDR_W'(band)] <= w_data;
        if (issue) ram_q <= mem[ADDR_W'(iss_slot) * BANDS_A + ADDR_W'(iss_band)];
    end

    // Output register with skid slot absorbing the RAM latency under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_data <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_data  <= skid_data;
                out_last  <= skid_last;
                out_vld   <= 1'b1;
                skid_vld  <= pend;
                skid_data <= ram_q;
                skid_last <= pend_last;
            end else if (pend) begin
                out_data <= ram_q;
                out_last <= pend_last;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end else if (pend) begin
            skid_vld  <= 1'b1;
            skid_data <= ram_q;
            skid_last <= pend_last;
        end
    end

    assign bus.win_rdy   = win_rdy;
    assign bus.rd_busy   = rd_busy;
    assign bus.rd_done   = rd_done;
    assign bus.feat_vld  = out_vld;
    assign bus.feat_data = out_data;
    assign bus.feat_last = out_vld & out_last;
    assign bus.drop_cnt  = drop_cnt;
    assign dbg_state     = state;
endmodule
